nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-cycle sequencer that adds two WIDTH-bit operands one 4-bit slice per clock, LSB slice first.
- Sits directly around the existing 4-bit carry-select adder. It drives that adder's a/b/c inputs, consumes its sum/carry outputs, registers the inter-slice carry, and assembles the full-width result.
- Lets the team build wide adders from the single 4-bit carry-select cell without replicating it.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4.
- NSLICE, WIDTH/4, derived (localparam); number of 4-bit slices / RUN cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled in IDLE or DONE only
- a  input  WIDTH  operand A, sampled when start accepted
- b  input  WIDTH  operand B, sampled when start accepted
- cin  input  1  carry-in, sampled when start accepted
- add_a  output  4  slice of A to the 4-bit adder's a input
- add_b  output  4  slice of B to the 4-bit adder's b input
- add_c  output  1  carry to the 4-bit adder's c input
- add_sum  input  4  4-bit adder sum output
- add_carry  input  1  4-bit adder carry output
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when result is valid
- sum  output  WIDTH  result; holds until next completion
- cout  output  1  final carry-out; holds until next completion

Behaviour:
- Reset (rst_n low, async): state=IDLE; busy=0, done=0, sum=0, cout=0; add_a=0, add_b=0, add_c=0; operand, carry and slice-index registers cleared. Release is synchronous to the next rising edge with no special handling.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at an edge latches a, b and cin into a_reg, b_reg and carry_reg, clears idx to 0, and moves to RUN. start=0 stays in IDLE.
- RUN: add_a = a_reg[4*idx+3:4*idx], add_b = b_reg[4*idx+3:4*idx], add_c = carry_reg. All three come directly from registers so the adder's tristate selects never see X.
- RUN, at each edge: acc[4*idx+3:4*idx] <= add_sum; carry_reg <= add_carry; idx <= idx+1.
- RUN exit: when idx==NSLICE-1 at the edge, go to DONE, sum <= acc with the final slice merged in, and cout <= add_carry.
- The combinational path add_a/add_b/add_c -> adder -> add_sum/add_carry must settle within one cycle. No pipelining of the adder.
- DONE lasts exactly one cycle with done=1, then the block returns to IDLE. start=1 in DONE is accepted exactly as in IDLE (back-to-back, no bubble) and goes to RUN.
- Latency: start accepted at edge 0 -> busy=1 from edge 0 to edge NSLICE -> done=1 and sum/cout valid after edge NSLICE. Throughput is one result per NSLICE+1 cycles.
- start while in RUN is ignored; a/b/cin changes during RUN have no effect.
- sum/cout change only on the RUN->DONE edge. They are stable in IDLE and during a subsequent RUN.
- add_a, add_b, add_c are 0 outside RUN.
- idx width: clog2(NSLICE), minimum 1 bit. For WIDTH=4, RUN lasts exactly one cycle.
- Arithmetic result: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Wrap-around appears as cout=1.
- Reset asserted mid-RUN aborts immediately: outputs return to reset values and the partial result is discarded. The next start after release behaves normally.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, start for 1 cycle -> busy high 4 cycles, done pulse after edge 4, sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> carry ripples through all 4 slices (add_c=1 on slices 1-3), sum=0x0000, cout=1.
- a=0xFFFF, b=0x0000, cin=1 -> add_c=1 on slice 0, sum=0x0000, cout=1. Then a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1.
- start held high through RUN with new a=0x1111 -> ignored, original result delivered. start=1 during the DONE cycle with a=0x0001, b=0x0002 -> next busy immediately, then sum=0x0003.
- rst_n low at RUN slice 2 -> busy=0, done=0, sum=0, cout=0, add_* = 0 asynchronously. After release, a=0x00FF + b=0x0001 -> sum=0x0100.
- WIDTH=4 build: a=0xF, b=0x1, cin=1 -> single RUN cycle, done at edge 1, sum=0x1, cout=1. Random 1000-vector check at WIDTH=16 and 32 against a+b+cin.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: sequences a WIDTH-bit addition through one external
// 4-bit carry-select adder cell, one slice per clock, LSB slice first.
// The inter-slice carry is held in a register, and the result is assembled
// slice by slice.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_c,
  input  logic [3:0]       add_sum,
  input  logic             add_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg, b_reg, acc, acc_nxt;
  logic             carry_reg;
  logic [IW-1:0]    idx;
  logic             last;

  assign last = (idx == IW'(NSLICE - 1));

  // Drive the adder cell from registers only. busy is a register that
  // mirrors RUN, so the outputs are zero outside RUN and never X.
  assign add_a = busy ? a_reg[{idx, 2'b00} +: 4] : 4'd0;
  assign add_b = busy ? b_reg[{idx, 2'b00} +: 4] : 4'd0;
  assign add_c = busy & carry_reg;

  // Accumulator with the current slice merged in. This value is what gets
  // published on the final RUN edge.
  always_comb begin
    acc_nxt = acc;
    acc_nxt[{idx, 2'b00} +: 4] = add_sum;
  end

  // Sequencer: accept work in IDLE or DONE, step one slice per cycle in RUN,
  // and publish sum/cout with a single-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            acc       <= '0;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc       <= acc_nxt;
          carry_reg <= add_carry;
          idx       <= idx + IW'(1);
          if (last) begin
            sum   <= acc_nxt;
            cout  <= add_carry;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder at WIDTH=4, 16 and 32. Each instance has a
// behavioural stand-in for the 4-bit adder cell. Expected results come from
// plain a+b+cin arithmetic.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_v = '0;
  logic [2:0]  cin_v = '0;
  logic [3:0]  a0 = '0, b0 = '0;
  logic [15:0] a1 = '0, b1 = '0;
  logic [31:0] a2 = '0, b2 = '0;

  wire [3:0]  aa0, ab0, as0, aa1, ab1, as1, aa2, ab2, as2;
  wire [2:0]  ac_v, aco_v, busy_v, done_v, cout_v;
  wire [3:0]  sum0;
  wire [15:0] sum1;
  wire [31:0] sum2;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // 4-bit adder cell models
  assign {aco_v[0], as0} = 5'(aa0) + 5'(ab0) + 5'(ac_v[0]);
  assign {aco_v[1], as1} = 5'(aa1) + 5'(ab1) + 5'(ac_v[1]);
  assign {aco_v[2], as2} = 5'(aa2) + 5'(ab2) + 5'(ac_v[2]);

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a0), .b(b0), .cin(cin_v[0]),
    .add_a(aa0), .add_b(ab0), .add_c(ac_v[0]), .add_sum(as0), .add_carry(aco_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum0), .cout(cout_v[0]));

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a1), .b(b1), .cin(cin_v[1]),
    .add_a(aa1), .add_b(ab1), .add_c(ac_v[1]), .add_sum(as1), .add_carry(aco_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum1), .cout(cout_v[1]));

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a2), .b(b2), .cin(cin_v[2]),
    .add_a(aa2), .add_b(ab2), .add_c(ac_v[2]), .add_sum(as2), .add_carry(aco_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum2), .cout(cout_v[2]));

  function automatic int wid(int s);
    return (s == 0) ? 4 : ((s == 1) ? 16 : 32);
  endfunction

  function automatic logic [31:0] o_sum(int s);
    logic [31:0] r;
    case (s)
      0:       r = {28'd0, sum0};
      1:       r = {16'd0, sum1};
      default: r = sum2;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] o_adda(int s);
    logic [3:0] r;
    case (s)
      0:       r = aa0;
      1:       r = aa1;
      default: r = aa2;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] o_addb(int s);
    logic [3:0] r;
    case (s)
      0:       r = ab0;
      1:       r = ab1;
      default: r = ab2;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int s, logic [31:0] av, logic [31:0] bv, logic ci);
    case (s)
      0:       begin a0 = av[3:0];  b0 = bv[3:0];  end
      1:       begin a1 = av[15:0]; b1 = bv[15:0]; end
      default: begin a2 = av;       b2 = bv;       end
    endcase
    cin_v[s] = ci;
  endtask

  // One complete operation on instance s. With detail set, busy, the slice
  // presented to the cell, and the carry into each slice are also checked.
  task automatic do_op(int s, logic [31:0] av, logic [31:0] bv, logic ci,
                       bit detail, string nm);
    int          w = wid(s);
    int          n = w / 4;
    longint      m = (64'd1 << w) - 1;
    longint      full = (longint'(av) & m) + (longint'(bv) & m) + longint'(ci);
    longint      lm;
    logic        exp_c;
    logic [3:0]  exp_a;
    drive(s, av, bv, ci);
    start_v[s] = 1'b1;
    tick();
    start_v[s] = 1'b0;
    drive(s, $urandom, $urandom, 1'($urandom_range(0, 1)));
    for (int k = 0; k < n; k++) begin
      if (detail) begin
        lm    = (64'd1 << (4 * k)) - 1;
        exp_c = 1'(((longint'(av) & lm) + (longint'(bv) & lm) + longint'(ci)) >> (4 * k));
        exp_a = 4'(longint'(av) >> (4 * k));
        checks++;
        if (busy_v[s] !== 1'b1) begin
          errs++; $display("FAIL %s busy slice %0d: got %b want 1", nm, k, busy_v[s]);
        end
        checks++;
        if (o_adda(s) !== exp_a) begin
          errs++; $display("FAIL %s add_a slice %0d: got %h want %h", nm, k, o_adda(s), exp_a);
        end
        checks++;
        if (ac_v[s] !== exp_c) begin
          errs++; $display("FAIL %s add_c slice %0d: got %b want %b", nm, k, ac_v[s], exp_c);
        end
      end
      tick();
    end
    checks++;
    if (done_v[s] !== 1'b1 || busy_v[s] !== 1'b0) begin
      errs++; $display("FAIL %s done/busy: got %b/%b want 1/0", nm, done_v[s], busy_v[s]);
    end
    checks++;
    if (o_sum(s) !== 32'(full & m) || cout_v[s] !== 1'(full >> w)) begin
      errs++;
      $display("FAIL %s result: got cout=%b sum=%h want cout=%b sum=%h", nm,
               cout_v[s], o_sum(s), 1'(full >> w), 32'(full & m));
    end
    tick();
    if (detail) begin
      checks++;
      if (done_v[s] !== 1'b0 || o_sum(s) !== 32'(full & m)) begin
        errs++; $display("FAIL %s idle hold: done=%b sum=%h want 0/%h", nm,
                         done_v[s], o_sum(s), 32'(full & m));
      end
    end
  endtask

  task automatic test_reset();
    #12;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if ({busy_v[s], done_v[s], cout_v[s], ac_v[s], o_adda(s), o_addb(s), o_sum(s)} !== '0) begin
        errs++;
        $display("FAIL reset inst %0d: busy=%b done=%b cout=%b add_c=%b add_a=%h add_b=%h sum=%h want all 0",
                 s, busy_v[s], done_v[s], cout_v[s], ac_v[s], o_adda(s), o_addb(s), o_sum(s));
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    do_op(1, 32'h1234, 32'h4321, 1'b0, 1, "plain");
    do_op(1, 32'hFFFF, 32'h0001, 1'b0, 1, "ripple");
    do_op(1, 32'hFFFF, 32'h0000, 1'b1, 1, "cin_ripple");
    do_op(1, 32'h8000, 32'h8000, 1'b0, 1, "msb_wrap");
  endtask

  task automatic test_back_to_back();
    drive(1, 32'h1234, 32'h4321, 1'b0);
    start_v[1] = 1'b1;
    tick();
    drive(1, 32'h1111, 32'h1111, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (busy_v[1] !== 1'b1) begin
        errs++; $display("FAIL b2b busy slice %0d: got %b want 1", k, busy_v[1]);
      end
      tick();
    end
    checks++;
    if (done_v[1] !== 1'b1 || sum1 !== 16'h5555 || cout_v[1] !== 1'b0) begin
      errs++; $display("FAIL b2b first: done=%b sum=%h cout=%b want 1/5555/0", done_v[1], sum1, cout_v[1]);
    end
    drive(1, 32'h0001, 32'h0002, 1'b0);
    tick();
    start_v[1] = 1'b0;
    checks++;
    if (busy_v[1] !== 1'b1 || done_v[1] !== 1'b0) begin
      errs++; $display("FAIL b2b restart: busy=%b done=%b want 1/0", busy_v[1], done_v[1]);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (sum1 !== 16'h5555) begin
        errs++; $display("FAIL b2b hold slice %0d: got sum=%h want 5555", k, sum1);
      end
      tick();
    end
    checks++;
    if (done_v[1] !== 1'b1 || sum1 !== 16'h0003 || cout_v[1] !== 1'b0) begin
      errs++; $display("FAIL b2b second: done=%b sum=%h cout=%b want 1/0003/0", done_v[1], sum1, cout_v[1]);
    end
    tick();
    tick();
    checks++;
    if (sum1 !== 16'h0003 || busy_v[1] !== 1'b0) begin
      errs++; $display("FAIL b2b idle: sum=%h busy=%b want 0003/0", sum1, busy_v[1]);
    end
  endtask

  task automatic test_reset_mid_run();
    drive(1, 32'hABCD, 32'h1111, 1'b1);
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_v[1], done_v[1], cout_v[1], ac_v[1], aa1, ab1, sum1} !== '0) begin
      errs++;
      $display("FAIL mid_reset: busy=%b done=%b cout=%b add_c=%b add_a=%h add_b=%h sum=%h want all 0",
               busy_v[1], done_v[1], cout_v[1], ac_v[1], aa1, ab1, sum1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy_v[1] !== 1'b0 || done_v[1] !== 1'b0) begin
      errs++; $display("FAIL mid_reset idle: busy=%b done=%b want 0/0", busy_v[1], done_v[1]);
    end
    do_op(1, 32'h00FF, 32'h0001, 1'b0, 1, "after_reset");
  endtask

  task automatic test_width4();
    do_op(0, 32'hF, 32'h1, 1'b1, 1, "w4_wrap");
    for (int i = 0; i < 40; i++)
      do_op(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1, "w4_rand");
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++)
      do_op(1, $urandom, $urandom, 1'($urandom_range(0, 1)), i < 20, "w16_rand");
    do_op(2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1, "w32_ripple");
    for (int i = 0; i < 1000; i++)
      do_op(2, $urandom, $urandom, 1'($urandom_range(0, 1)), i < 20, "w32_rand");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_run();
    test_width4();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
